// File: rtl/cp0_reg_if.sv
// MTC0/MFC0 register access bus for the CP0 register file.
// The master drives write/read requests and the slave returns combinational read data.
interface cp0_reg_if;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [2:0]  cp0_wsel;
  logic [31:0] cp0_wdata;
  logic [4:0]  cp0_raddr;
  logic [2:0]  cp0_rsel;
  logic [31:0] cp0_rdata;

  modport master (
    output cp0_we, cp0_waddr, cp0_wsel, cp0_wdata, cp0_raddr, cp0_rsel,
    input  cp0_rdata
  );

  modport slave (
    input  cp0_we, cp0_waddr, cp0_wsel, cp0_wdata, cp0_raddr, cp0_rsel,
    output cp0_rdata
  );
endinterface

// File: rtl/cp0_reg.sv
// MIPS CP0 register file: Status/Cause/EPC/BadVAddr/PRId/EBase with exception commit and ERET.
// Define CP0_TIMER_INT_EN to build the Count/Compare timer and its interrupt.
module cp0_reg (
  input  logic           clk,
  input  logic           rst_n,
  cp0_reg_if.slave       bus,
  input  logic [5:0]     hw_int,
  input  logic           exp_we,
  input  logic [4:0]     exp_code,
  input  logic [31:0]    exp_epc,
  input  logic           exp_in_delayslot,
  input  logic           exp_clean_exl,
  input  logic           exp_badv_we,
  input  logic [31:0]    exp_bad_vaddr,
  output logic [31:0]    epc_out,
  output logic [19:0]    ebase_out,
  output logic           allow_int,
  output logic [7:0]     interrupt_flags,
  output logic           special_int_vec,
  output logic           boot_exp_vec,
  output logic           timer_int
);

  localparam logic [7:0] AddrBadv   = {5'd8, 3'd0};
  localparam logic [7:0] AddrStatus = {5'd12, 3'd0};
  localparam logic [7:0] AddrCause  = {5'd13, 3'd0};
  localparam logic [7:0] AddrEpc    = {5'd14, 3'd0};
  localparam logic [7:0] AddrPrid   = {5'd15, 3'd0};
  localparam logic [7:0] AddrEbase  = {5'd15, 3'd1};
  localparam logic [31:0] PridValue = 32'h0001_8000;

  logic        bev_q, bev_d, erl_q, erl_d, exl_q, exl_d, ie_q, ie_d;
  logic [7:0]  im_q, im_d;
  logic        bd_q, bd_d, iv_q, iv_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [5:0]  hw_q;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d, badv_q, badv_d;
  logic [17:0] ebase_q, ebase_d;

  logic        ti;
  logic [7:0]  ip;
  logic [7:0]  wkey;
  logic        mtc0_en;
  logic        wr_status, wr_cause, wr_epc, wr_ebase;
  logic [31:0] status_rd, cause_rd, rdata;

  // An exception commit or ERET in the same cycle discards the whole MTC0.
  assign mtc0_en   = bus.cp0_we & ~exp_we & ~exp_clean_exl;
  assign wkey      = {bus.cp0_waddr, bus.cp0_wsel};
  assign wr_status = mtc0_en && (wkey == AddrStatus);
  assign wr_cause  = mtc0_en && (wkey == AddrCause);
  assign wr_epc    = mtc0_en && (wkey == AddrEpc);
  assign wr_ebase  = mtc0_en && (wkey == AddrEbase);

`ifdef CP0_TIMER_INT_EN
  localparam logic [7:0] AddrCount   = {5'd9, 3'd0};
  localparam logic [7:0] AddrCompare = {5'd11, 3'd0};

  logic [31:0] count_q, count_d, compare_q, compare_d;
  logic        phase_q, phase_d, ti_q, ti_d, count_load;
  logic        wr_count, wr_compare;

  assign wr_count   = mtc0_en && (wkey == AddrCount);
  assign wr_compare = mtc0_en && (wkey == AddrCompare);

  always_comb begin
    phase_d    = ~phase_q;
    count_d    = phase_q ? count_q + 32'd1 : count_q;
    count_load = phase_q;
    compare_d  = compare_q;
    ti_d       = ti_q;
    if (wr_count) begin
      count_d    = bus.cp0_wdata;
      phase_d    = 1'b0;
      count_load = 1'b1;
    end
    if (wr_compare) begin
      compare_d = bus.cp0_wdata;
    end
    // Match only on an edge that actually registers a new Count value.
    if (wr_compare) begin
      ti_d = 1'b0;
    end else if (count_load && (count_d == compare_q)) begin
      ti_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      compare_q <= '0;
      phase_q   <= 1'b0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      phase_q   <= phase_d;
      ti_q      <= ti_d;
    end
  end

  assign ti = ti_q;
`else
  assign ti = 1'b0;
`endif

  always_comb begin
    bev_d      = bev_q;
    im_d       = im_q;
    erl_d      = erl_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    iv_d       = iv_q;
    ip_sw_d    = ip_sw_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    badv_d     = badv_q;
    ebase_d    = ebase_q;
    if (wr_status) begin
      bev_d = bus.cp0_wdata[22];
      im_d  = bus.cp0_wdata[15:8];
      erl_d = bus.cp0_wdata[2];
      exl_d = bus.cp0_wdata[1];
      ie_d  = bus.cp0_wdata[0];
    end
    if (wr_cause) begin
      iv_d    = bus.cp0_wdata[23];
      ip_sw_d = bus.cp0_wdata[9:8];
    end
    if (wr_epc) begin
      epc_d = bus.cp0_wdata;
    end
    if (wr_ebase) begin
      ebase_d = bus.cp0_wdata[29:12];
    end
    // Nested exceptions keep the EPC/BD of the outermost one.
    if (exp_we) begin
      exl_d      = 1'b1;
      exc_code_d = exp_code;
      if (!exl_q) begin
        epc_d = exp_epc;
        bd_d  = exp_in_delayslot;
      end
    end else if (exp_clean_exl) begin
      if (erl_q) begin
        erl_d = 1'b0;
      end else begin
        exl_d = 1'b0;
      end
    end
    if (exp_badv_we) begin
      badv_d = exp_bad_vaddr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bev_q      <= 1'b1;
      im_q       <= '0;
      erl_q      <= 1'b1;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      iv_q       <= 1'b0;
      ip_sw_q    <= '0;
      hw_q       <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
      badv_q     <= '0;
      ebase_q    <= '0;
    end else begin
      bev_q      <= bev_d;
      im_q       <= im_d;
      erl_q      <= erl_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      iv_q       <= iv_d;
      ip_sw_q    <= ip_sw_d;
      hw_q       <= hw_int;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
      badv_q     <= badv_d;
      ebase_q    <= ebase_d;
    end
  end

  // All six hardware lines pass through the same one-cycle sampling register.
  assign ip        = {hw_q[5] | ti, hw_q[4:0], ip_sw_q};
  assign status_rd = {9'b0, bev_q, 6'b0, im_q, 5'b0, erl_q, exl_q, ie_q};
  assign cause_rd  = {bd_q, ti, 6'b0, iv_q, 7'b0, ip, 1'b0, exc_code_q, 2'b0};

  always_comb begin
    rdata = '0;
    case ({bus.cp0_raddr, bus.cp0_rsel})
      AddrBadv:    rdata = badv_q;
`ifdef CP0_TIMER_INT_EN
      AddrCount:   rdata = count_q;
      AddrCompare: rdata = compare_q;
`endif
      AddrStatus:  rdata = status_rd;
      AddrCause:   rdata = cause_rd;
      AddrEpc:     rdata = epc_q;
      AddrPrid:    rdata = PridValue;
      AddrEbase:   rdata = {2'b10, ebase_q, 12'b0};
      default:     rdata = '0;
    endcase
  end

  assign bus.cp0_rdata    = rdata;
  assign epc_out          = epc_q;
  assign ebase_out        = {2'b10, ebase_q};
  assign allow_int        = ~erl_q & ~exl_q & ie_q;
  assign interrupt_flags  = ip & im_q;
  assign special_int_vec  = iv_q;
  assign boot_exp_vec     = bev_q;
  assign timer_int        = ti;

endmodule

// File: tb/tb_cp0_reg.sv
// Randomized self-checking bench for cp0_reg against a register-image reference model.
// Directed sections anchor reset, exception, ERET and timer behaviour with fixed expectations.
module tb_cp0_reg;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cp0_reg_if bus ();

  logic [5:0]  hw_int;
  logic        exp_we, exp_in_delayslot, exp_clean_exl, exp_badv_we;
  logic [4:0]  exp_code;
  logic [31:0] exp_epc, exp_bad_vaddr, epc_out;
  logic [19:0] ebase_out;
  logic        allow_int, special_int_vec, boot_exp_vec, timer_int;
  logic [7:0]  interrupt_flags;

  cp0_reg dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus),
    .hw_int           (hw_int),
    .exp_we           (exp_we),
    .exp_code         (exp_code),
    .exp_epc          (exp_epc),
    .exp_in_delayslot (exp_in_delayslot),
    .exp_clean_exl    (exp_clean_exl),
    .exp_badv_we      (exp_badv_we),
    .exp_bad_vaddr    (exp_bad_vaddr),
    .epc_out          (epc_out),
    .ebase_out        (ebase_out),
    .allow_int        (allow_int),
    .interrupt_flags  (interrupt_flags),
    .special_int_vec  (special_int_vec),
    .boot_exp_vec     (boot_exp_vec),
    .timer_int        (timer_int)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: architectural register images, updated by write masks.
  logic [31:0] m_status, m_cause, m_epc, m_badv, m_ebase;
  logic [5:0]  m_hw;
  logic        m_ti;
`ifdef CP0_TIMER_INT_EN
  logic [31:0] m_count, m_compare;
  logic        m_phase;
`endif

  localparam logic [31:0] StatusMask = 32'h0040_FF07;
  localparam logic [31:0] CauseMask  = 32'h0080_0300;
  localparam logic [31:0] EbaseMask  = 32'h3FFF_F000;

  function automatic void model_reset();
    m_status = 32'h0040_0004;
    m_cause  = '0;
    m_epc    = '0;
    m_badv   = '0;
    m_ebase  = 32'h8000_0000;
    m_hw     = '0;
    m_ti     = 1'b0;
`ifdef CP0_TIMER_INT_EN
    m_count   = '0;
    m_compare = '0;
    m_phase   = 1'b0;
`endif
  endfunction

  function automatic logic [7:0] m_ip();
    return {m_hw[5] | m_ti, m_hw[4:0], m_cause[9:8]};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic [2:0] s);
    logic [7:0] k;
    k = {a, s};
    if (k == {5'd8, 3'd0})  return m_badv;
`ifdef CP0_TIMER_INT_EN
    if (k == {5'd9, 3'd0})  return m_count;
    if (k == {5'd11, 3'd0}) return m_compare;
`endif
    if (k == {5'd12, 3'd0}) return m_status;
    if (k == {5'd13, 3'd0}) return m_cause | (32'(m_ti) << 30) | (32'(m_ip()) << 8);
    if (k == {5'd14, 3'd0}) return m_epc;
    if (k == {5'd15, 3'd0}) return 32'h0001_8000;
    if (k == {5'd15, 3'd1}) return m_ebase;
    return 32'h0;
  endfunction

  function automatic void model_step();
    logic        ok;
    logic [7:0]  k;
    logic [31:0] wd, n_status, n_cause, n_epc, n_badv, n_ebase;
    logic        n_ti;
`ifdef CP0_TIMER_INT_EN
    logic [31:0] n_count, n_compare;
    logic        n_phase, load;
`endif
    ok = bus.cp0_we && !exp_we && !exp_clean_exl;
    k  = {bus.cp0_waddr, bus.cp0_wsel};
    wd = bus.cp0_wdata;
    n_status = m_status; n_cause = m_cause; n_epc = m_epc; n_badv = m_badv;
    n_ebase = m_ebase; n_ti = m_ti;
`ifdef CP0_TIMER_INT_EN
    n_phase = !m_phase;
    n_count = m_phase ? m_count + 32'd1 : m_count;
    load = m_phase;
    n_compare = m_compare;
`endif
    if (ok) begin
      if (k == {5'd12, 3'd0}) n_status = (m_status & ~StatusMask) | (wd & StatusMask);
      if (k == {5'd13, 3'd0}) n_cause = (m_cause & ~CauseMask) | (wd & CauseMask);
      if (k == {5'd14, 3'd0}) n_epc = wd;
      if (k == {5'd15, 3'd1}) n_ebase = 32'h8000_0000 | (wd & EbaseMask);
`ifdef CP0_TIMER_INT_EN
      if (k == {5'd9, 3'd0}) begin
        n_count = wd;
        n_phase = 1'b0;
        load = 1'b1;
      end
      if (k == {5'd11, 3'd0}) n_compare = wd;
`endif
    end
`ifdef CP0_TIMER_INT_EN
    if (ok && k == {5'd11, 3'd0}) n_ti = 1'b0;
    else if (load && n_count == m_compare) n_ti = 1'b1;
`endif
    if (exp_we) begin
      n_status[1] = 1'b1;
      n_cause[6:2] = exp_code;
      if (!m_status[1]) begin
        n_epc = exp_epc;
        n_cause[31] = exp_in_delayslot;
      end
    end else if (exp_clean_exl) begin
      if (m_status[2]) n_status[2] = 1'b0;
      else n_status[1] = 1'b0;
    end
    if (exp_badv_we) n_badv = exp_bad_vaddr;
    m_status = n_status; m_cause = n_cause; m_epc = n_epc; m_badv = n_badv;
    m_ebase = n_ebase; m_ti = n_ti; m_hw = hw_int;
`ifdef CP0_TIMER_INT_EN
    m_count = n_count; m_compare = n_compare; m_phase = n_phase;
`endif
  endfunction

  task automatic check_outputs();
    check("rdata", bus.cp0_rdata, m_read(bus.cp0_raddr, bus.cp0_rsel));
    check("epc_out", epc_out, m_epc);
    check("ebase_out", {12'b0, ebase_out}, {12'b0, m_ebase[31:12]});
    check("flags", {20'b0, allow_int, special_int_vec, boot_exp_vec, timer_int, interrupt_flags},
          {20'b0, m_status[2:0] == 3'b001, m_cause[23], m_status[22], m_ti,
           m_ip() & m_status[15:8]});
  endtask

  // Inputs are driven just after a negedge; this samples, advances the model and one edge.
  task automatic tick();
    #1;
    check_outputs();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_idle();
    bus.cp0_we = 1'b0; bus.cp0_waddr = '0; bus.cp0_wsel = '0; bus.cp0_wdata = '0;
    exp_we = 1'b0; exp_code = '0; exp_epc = '0; exp_in_delayslot = 1'b0;
    exp_clean_exl = 1'b0; exp_badv_we = 1'b0; exp_bad_vaddr = '0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
    bus.cp0_we = 1'b1; bus.cp0_waddr = a; bus.cp0_wsel = s; bus.cp0_wdata = d;
    tick();
    bus.cp0_we = 1'b0;
  endtask

  task automatic peek(input logic [4:0] a, input logic [2:0] s);
    bus.cp0_raddr = a;
    bus.cp0_rsel = s;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    hw_int = 6'($urandom);
    exp_we = 1'b1;
    exp_epc = $urandom;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("rst_boot", {31'b0, boot_exp_vec}, 32'h1);
    check("rst_allow", {31'b0, allow_int}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    set_idle();
    hw_int = '0;
    rst_n = 1'b1;
  endtask

  function automatic logic [4:0] pick_addr();
    case ($urandom_range(0, 7))
      0: return 5'd8;
      1: return 5'd9;
      2: return 5'd11;
      3: return 5'd12;
      4: return 5'd13;
      5: return 5'd14;
      6: return 5'd15;
      default: return 5'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [4:0] a;
    set_idle();
    hw_int = '0;
    bus.cp0_raddr = 5'd12;
    bus.cp0_rsel = 3'd0;
    do_reset();

    peek(5'd12, 3'd0); check("rst_status", bus.cp0_rdata, 32'h0040_0004);
    peek(5'd15, 3'd1); check("rst_ebase", bus.cp0_rdata, 32'h8000_0000);
    peek(5'd15, 3'd0); check("prid", bus.cp0_rdata, 32'h0001_8000);

    // Interrupt enable path.
    hw_int = 6'b000001;
    mtc0(5'd12, 3'd0, 32'h0000_FF01);
    tick();
    check("int_flags", {24'b0, interrupt_flags}, 32'h04);
    check("int_allow", {31'b0, allow_int}, 32'h1);

    // First and nested exception.
    hw_int = '0;
    tick();
    exp_we = 1'b1; exp_epc = 32'hBFC0_0100; exp_in_delayslot = 1'b1; exp_code = 5'h0C;
    tick();
    set_idle();
    peek(5'd13, 3'd0); check("exc_cause", bus.cp0_rdata, 32'h8000_0030);
    check("exc_epc", epc_out, 32'hBFC0_0100);
    peek(5'd12, 3'd0); check("exc_status", bus.cp0_rdata, 32'h0000_FF03);
    exp_we = 1'b1; exp_epc = 32'h0000_1234; exp_code = 5'h04;
    tick();
    set_idle();
    check("nest_epc", epc_out, 32'hBFC0_0100);
    peek(5'd13, 3'd0); check("nest_cause", bus.cp0_rdata, 32'h8000_0010);

    // ERET, then exception beating a same-cycle MTC0.
    exp_clean_exl = 1'b1;
    tick();
    set_idle();
    peek(5'd12, 3'd0); check("eret_exl", bus.cp0_rdata, 32'h0000_FF01);
    exp_we = 1'b1; exp_epc = 32'h0040_0020;
    bus.cp0_we = 1'b1; bus.cp0_waddr = 5'd14; bus.cp0_wdata = 32'hDEAD_BEEF;
    tick();
    set_idle();
    check("mtc0_lost", epc_out, 32'h0040_0020);
    exp_clean_exl = 1'b1;
    tick();
    set_idle();
    peek(5'd12, 3'd0); check("eret_exl2", bus.cp0_rdata, 32'h0000_FF01);
    mtc0(5'd12, 3'd0, 32'h0000_0006);
    exp_clean_exl = 1'b1;
    tick();
    set_idle();
    peek(5'd12, 3'd0); check("eret_erl", bus.cp0_rdata, 32'h0000_0002);

`ifdef CP0_TIMER_INT_EN
    mtc0(5'd11, 3'd0, 32'd10);
    mtc0(5'd9, 3'd0, 32'd0);
    n = 0;
    while (!timer_int && n < 40) begin
      tick();
      n++;
    end
    check("ti_latency", 32'(n), 32'd20);
    peek(5'd9, 3'd0); check("ti_count", bus.cp0_rdata, 32'd10);
    mtc0(5'd11, 3'd0, 32'd100);
    check("ti_clear", {31'b0, timer_int}, 32'h0);
    mtc0(5'd9, 3'd0, 32'hFFFF_FFFF);
    tick();
    tick();
    peek(5'd9, 3'd0); check("count_wrap", bus.cp0_rdata, 32'h0);
    check("wrap_ti", {31'b0, timer_int}, 32'h0);
`else
    mtc0(5'd9, 3'd0, 32'd5);
    peek(5'd9, 3'd0); check("count_off", bus.cp0_rdata, 32'h0);
    check("timer_off", {31'b0, timer_int}, 32'h0);
`endif

    for (int i = 0; i < 1500; i++) begin
      if (i == 750) begin
        do_reset();
        peek(5'd12, 3'd0); check("rst2_status", bus.cp0_rdata, 32'h0040_0004);
      end
      a = pick_addr();
      bus.cp0_we = ($urandom_range(0, 3) == 0);
      bus.cp0_waddr = a;
      bus.cp0_wsel = (a == 5'd15) ? 3'($urandom_range(0, 1)) :
                     (($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd0);
      bus.cp0_wdata = $urandom;
`ifdef CP0_TIMER_INT_EN
      if (a == 5'd9 && $urandom_range(0, 1) == 1)
        bus.cp0_wdata = m_compare - 32'($urandom_range(0, 3));
`endif
      bus.cp0_raddr = pick_addr();
      bus.cp0_rsel = (bus.cp0_raddr == 5'd15) ? 3'($urandom_range(0, 1)) : 3'd0;
      exp_we = ($urandom_range(0, 11) == 0);
      exp_code = 5'($urandom);
      exp_epc = $urandom;
      exp_in_delayslot = 1'($urandom);
      exp_clean_exl = ($urandom_range(0, 11) == 0);
      exp_badv_we = ($urandom_range(0, 7) == 0);
      exp_bad_vaddr = $urandom;
      if ($urandom_range(0, 7) == 0) hw_int = 6'($urandom);
      tick();
    end
    set_idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
